// File: rtl/rsfq_pulse_tx.sv
// rsfq_pulse_tx: serialises parallel words onto toggle-encoded RSFQ data/clock pulse lines
module rsfq_pulse_tx #(
    parameter int WIDTH       = 8,
    parameter int DATA_TO_CLK = 4,
    parameter int CLK_TO_DATA = 4,
    parameter bit MSB_FIRST   = 1'b0,
    parameter int CNT_W       = 16,
    localparam int BW         = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             pulse_data,
    output logic             pulse_clk,
    output logic             busy,
    output logic [BW-1:0]    bit_idx,
    output logic [CNT_W-1:0] words_sent
);
    localparam int GMAX = (DATA_TO_CLK > CLK_TO_DATA) ? DATA_TO_CLK : CLK_TO_DATA;
    localparam int GW   = $clog2(GMAX + 1);
    localparam logic [GW-1:0] D_END = GW'(DATA_TO_CLK);
    localparam logic [GW-1:0] C_END = GW'(CLK_TO_DATA - 1);
    localparam logic [BW-1:0] LAST  = BW'(WIDTH - 1);
    localparam bit C_ONE = (CLK_TO_DATA == 1);

    typedef enum logic [1:0] {IDLE, DATA_GAP, CLK_GAP} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [GW-1:0]    r_cnt;
    logic [BW-1:0]    r_bit;
    logic [BW-1:0]    r_bit_idx;
    logic [CNT_W-1:0] r_words;
    logic             r_ready;
    logic             r_busy;
    logic             r_data;
    logic             r_clk;
    logic             w_bit;
    logic             w_last;
    logic             w_gap_end;

    assign w_bit  = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    assign w_last = (r_bit == LAST);
    // The post-clock gap ends one edge before the next data slot; with a one-cycle gap that is the clock edge itself
    assign w_gap_end = (r_state == CLK_GAP && r_cnt == C_END) ||
                       (C_ONE && r_state == DATA_GAP && r_cnt == D_END);

    assign word_ready = r_ready;
    assign busy       = r_busy;
    assign pulse_data = r_data;
    assign pulse_clk  = r_clk;
    assign bit_idx    = r_bit_idx;
    assign words_sent = r_words;

    // Sequencer: r_cnt counts edges since the data slot (DATA_GAP) or since the clock pulse (CLK_GAP)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_bit_idx <= '0;
            r_words   <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_data    <= 1'b0;
            r_clk     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    if (word_valid && r_ready) begin
                        r_shift   <= word_in;
                        r_cnt     <= '0;
                        r_bit     <= '0;
                        r_bit_idx <= '0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= DATA_GAP;
                    end
                end
                DATA_GAP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == '0) begin
                        r_data    <= r_data ^ w_bit;
                        r_bit_idx <= r_bit;
                        r_shift   <= MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
                    end
                    if (r_cnt == D_END) begin
                        r_clk   <= ~r_clk;
                        r_cnt   <= GW'(1);
                        r_state <= CLK_GAP;
                    end
                end
                CLK_GAP: r_cnt <= r_cnt + 1'b1;
                default: r_state <= IDLE;
            endcase
            if (w_gap_end) begin
                if (w_last) begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_words <= r_words + 1'b1;
                end else begin
                    r_state <= DATA_GAP;
                    r_cnt   <= '0;
                    r_bit   <= r_bit + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/rsfq_pulse_tx.md
Name: rsfq_pulse_tx

Overview:
- Conventional-clock transmitter that drives RSFQ cell behavioural models, such as the clocked NOT and DFF models.
- Accepts parallel words on a valid/ready interface and serialises each one onto two toggle-encoded pulse lines: data and clock.
- One pulse is one transition (either edge) of a line, which is the encoding the cell models decode.
- Programmable gaps place each data pulse a fixed distance before its clock pulse, so bench stimulus stays outside the cells' critical-timing windows.

Parameters:
WIDTH, 8, bits per word (≥1)
DATA_TO_CLK, 4, sys-clock cycles from a bit's data-pulse slot to its clock pulse (≥1)
CLK_TO_DATA, 4, sys-clock cycles from a clock pulse to the next bit's data-pulse slot (≥1)
MSB_FIRST, 0, 0 = LSB transmitted first, 1 = MSB transmitted first
CNT_W, 16, width of the words_sent counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
word_in  input  WIDTH  word to transmit
word_valid  input  1  word_in valid
word_ready  output  1  block can accept a word (high only in IDLE)
pulse_data  output  1  toggle-encoded data pulse line
pulse_clk  output  1  toggle-encoded clock pulse line
busy  output  1  word in flight (inverse of word_ready when out of reset)
bit_idx  output  clog2(WIDTH) or 1 bit if WIDTH=1  index of bit currently being sent
words_sent  output  CNT_W  count of completed words, wraps

Behaviour:
- All outputs are registered.
- Reset (asynchronous, immediate): state IDLE, pulse_data=0, pulse_clk=0, word_ready=0 while rst is high, then 1 from the first clk edge after rst falls, busy=0, bit_idx=0, words_sent=0.
- Period P = DATA_TO_CLK + CLK_TO_DATA.
- States: IDLE, DATA_GAP, CLK_GAP.
- IDLE:
  - word_ready=1.
  - A word is accepted on an edge with word_valid && word_ready; call that edge E0.
  - On E0: load shift register, bit_idx=0, go to DATA_GAP, busy=1, word_ready=0.
- Data pulse slot for bit i is at edge E0+1+i*P.
  - If the bit is 1, pulse_data toggles on that edge.
  - If the bit is 0, the line holds; the slot timing is unchanged.
- Clock pulse for bit i is at edge E0+1+i*P+DATA_TO_CLK; pulse_clk always toggles, once per bit.
- bit_idx updates on each data-slot edge.
- Bit order follows MSB_FIRST. The bit value is the one captured at E0; later changes to word_in have no effect.
- After the last clock pulse the block waits CLK_TO_DATA cycles.
  - On edge E0+WIDTH*P: return to IDLE, word_ready=1, busy=0, words_sent += 1 (wraps at 2^CNT_W).
- Earliest next acceptance is edge E0+WIDTH*P+1.
  - Back-to-back words therefore keep data-slot spacing ≥ CLK_TO_DATA+1 after the previous clock pulse.
  - No pulse is ever dropped or merged.
- Edges where word_valid is high while word_ready is low are ignored; no capture, no stall error.
- Pulse line levels are not reset between words. The level carries over, and only transitions carry meaning.
- Reset mid-word:
  - Abort immediately; the word is not counted.
  - Lines forced to 0, which may produce at most one artifact transition per line while rst is high.
  - Benches shall not count pulses while rst=1.
- Counters: the gap counter is wide enough for max(DATA_TO_CLK, CLK_TO_DATA). A gap of 1 means the events are on consecutive edges.

Test Plan:
- Defaults, reset, then word_in=0xA5 accepted at E0:
  - pulse_data toggles at E0+1, +17, +41, +57 only.
  - pulse_clk toggles at E0+5, +13, …, +61 (8 toggles).
  - word_ready rises after E0+64; words_sent=1; both lines end at 0.
- word_in=0x00 → zero pulse_data transitions, exactly 8 pulse_clk transitions at the same edges as above.
- 0xFF then 0xFF with word_valid held high:
  - Second word accepted at E0+65; its first data toggle at E0+66.
  - 16 data and 16 clock toggles total; words_sent=2.
  - Data toggle is never within CLK_TO_DATA cycles after a clock toggle.
- MSB_FIRST=1, word_in=0x01 → single data toggle at E0+57, one DATA_TO_CLK before the 8th clock toggle.
- Reset asserted asynchronously between edges during bit 3 of 0xFF:
  - Lines go to 0 without waiting for a clk edge; state IDLE; words_sent unchanged.
  - A new word sends cleanly after rst falls.
- DATA_TO_CLK=1, CLK_TO_DATA=1, WIDTH=4, word 0xF:
  - Data/clock toggles alternate on consecutive edges E0+1 … E0+8.
  - word_ready rises after E0+8.
